run_length_expander: RTL

RUN_LENGTH_EXPANDER -- requirements
Module: run_length_expander

---
 rtl/run_length_expander.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/run_length_expander.sv
// Run-length expander: turns (value, count, last) pairs into a stream of
// repeated elements, one frame per in_last pair. Output frames are capped at
// MAX_LEN beats; anything beyond the cap is swallowed and flagged as overflow.
module run_length_expander #(
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 6,
  parameter int MAX_LEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_value,
  input  logic [CNT_W-1:0]  in_count,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_value,
  output logic              out_last,
  output logic [5:0]        total_len,
  output logic              overflow,
  output logic              done
);

  localparam int LEN_W = 6;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    EMIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   value_q;
  logic [CNT_W-1:0]    rem_q;
  logic                last_q;
  logic                new_frame_q;

  logic accept;
  logic handshake;
  logic final_rep;
  logic at_max;
  logic done_d;
  logic overflow_set;
  logic load_pair;

  // Handshake qualifiers and beat position within the current pair / frame.
  assign in_ready  = (state_q != EMIT);
  assign out_valid = (state_q == EMIT);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;
  assign final_rep = (rem_q == CNT_W'(1));
  assign at_max    = (total_len == LEN_W'(MAX_LEN - 1));
  assign load_pair = (state_q == LOAD) && accept && (in_count != '0);

  assign out_value = value_q;
  // The cap forces out_last so a truncated frame still closes cleanly downstream.
  assign out_last  = (state_q == EMIT) && ((final_rep && last_q) || at_max);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering in simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  // Next-state decode plus the done / overflow events it implies.
  // NOTE: every signal is given a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    done_d       = 1'b0;
    overflow_set = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          if (in_count != '0) state_d = EMIT;
          else if (in_last)   done_d  = 1'b1;
        end
      end
      EMIT: begin
        if (handshake) begin
          if (at_max) begin
            if (final_rep && last_q) begin
              state_d = LOAD;
              done_d  = 1'b1;
            end else begin
              state_d      = DRAIN;
              overflow_set = 1'b1;
            end
          end else if (final_rep) begin
            state_d = LOAD;
            done_d  = last_q;
          end
        end
      end
      DRAIN: begin
        if (accept && in_last) begin
          state_d = LOAD;
          done_d  = 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Pair holding registers: latched on accept, counted down per output beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
    end else if (load_pair) begin
      value_q <= in_value;
      rem_q   <= in_count;
      last_q  <= in_last;
    end else if (handshake) begin
      rem_q   <= rem_q - CNT_W'(1);
    end
  end

  // Frame statistics: cleared by the first accept of a new frame, then held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_len <= '0;
      overflow  <= 1'b0;
    end else if (accept && new_frame_q) begin
      total_len <= '0;
      overflow  <= 1'b0;
    end else if (handshake) begin
      total_len <= total_len + LEN_W'(1);
      if (overflow_set) overflow <= 1'b1;
    end
  end

  // Frame boundary tracking and the registered done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done        <= 1'b0;
      new_frame_q <= 1'b1;
    end else begin
      done <= done_d;
      if (done_d)      new_frame_q <= 1'b1;
      else if (accept) new_frame_q <= 1'b0;
    end
  end

endmodule
